serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor: diff = a - b - bin, computed LSB-first, one bit per clock.
- Core is a single full-subtractor cell: d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br). A borrow flip-flop carries br between bits.
- Small datapath block with valid/ready handshakes on both sides, placed next to the team's adder cells.
- Trades latency for area against a ripple subtractor.

---
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB-first, one bit per clock,
// built around a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {borrow_next, difference_bit} for one bit position.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
        logic d;
        logic br_next;
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
        return {br_next, d};
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic            br_r;
    logic [CW-1:0]   cnt_r;
    logic            bout_r;
    logic            ovf_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic            x_s;
    logic            y_s;
    logic            d_s;
    logic            br_next_s;
    logic            last_s;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        x_s       = a_sh_r[0];
        y_s       = b_sh_r[0];
        {br_next_s, d_s} = full_sub(x_s, y_s, br_r);
        last_s    = (cnt_r == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s == RUN);
        end
    end

    // Operand capture, serial compute and result registers; results hold outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            diff_r <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        diff_r <= '0;
                        cnt_r  <= '0;
                    end
                end
                RUN: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    br_r   <= br_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    // The MSB pass decides the final borrow and signed overflow.
                    if (last_s) begin
                        bout_r <= br_next_s;
                        ovf_r  <= (x_s ^ y_s) & (d_s ^ x_s);
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, backpressure and
// mid-run reset sequences, and random operands checked against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus the sign rule for overflow.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                                  output logic [7:0] md, output logic mbo, output logic mov);
        int t;
        t   = int'(ma) - int'(mb) - int'(mbin);
        md  = t[7:0];
        mbo = (t < 0);
        mov = (ma[7] != mb[7]) && (md[7] != ma[7]);
    endfunction

    // One complete transaction; checks latency, busy width and the release handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input logic early_ready, input string tag,
                          output logic [7:0] gd, output logic gbo, output logic gov);
        int n;
        int bc;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        bin       = tbin;
        out_ready = early_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        bin      = 1'($urandom_range(0, 1));
        n  = 0;
        bc = 0;
        while (!out_valid && n < 20) begin
            if (busy) bc++;
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'(W));
        check({tag, " busy_cycles"}, 64'(bc), 64'(W));
        check({tag, " in_ready_done"}, 64'(in_ready), 64'(1'b0));
        gd  = diff;
        gbo = bout;
        gov = ovf;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_release"}, 64'(out_valid), 64'(1'b0));
        check({tag, " in_ready_release"}, 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        logic [7:0] gd;
        logic       gbo;
        logic       gov;
        logic [7:0] ed;
        logic       ebo;
        logic       eov;
        logic [7:0] hd;
        logic       hbo;
        logic       hov;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'(1'b1));
        check("rst out_valid", 64'(out_valid), 64'(1'b0));
        check("rst busy", 64'(busy), 64'(1'b0));
        check("rst diff", 64'(diff), 64'(8'h00));
        check("rst bout", 64'(bout), 64'(1'b0));
        check("rst ovf", 64'(ovf), 64'(1'b0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, $sformatf("tbl%0d", i), gd, gbo, gov);
            check($sformatf("tbl%0d diff", i), 64'(gd), 64'(tbl[i].d));
            check($sformatf("tbl%0d bout", i), 64'(gbo), 64'(tbl[i].bo));
            check($sformatf("tbl%0d ovf", i), 64'(gov), 64'(tbl[i].ov));
        end

        // Backpressure with ignored input traffic during RUN and DONE
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h5A;
        b = 8'h3C;
        bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("bp out_valid", 64'(out_valid), 64'(1'b1));
        hd = diff;
        hbo = bout;
        hov = ovf;
        check("bp diff", 64'(hd), 64'(8'h1E));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold diff", 64'(diff), 64'(hd));
            check("bp hold bout", 64'(bout), 64'(hbo));
            check("bp hold ovf", 64'(ovf), 64'(hov));
            check("bp hold in_ready", 64'(in_ready), 64'(1'b0));
            check("bp hold out_valid", 64'(out_valid), 64'(1'b1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp release out_valid", 64'(out_valid), 64'(1'b0));
        check("bp release in_ready", 64'(in_ready), 64'(1'b1));
        check("bp release diff", 64'(diff), 64'(8'h1E));
        @(negedge clk);
        check("bp no restart busy", 64'(busy), 64'(1'b0));

        // Reset after three compute cycles
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h5A;
        b = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst in_ready", 64'(in_ready), 64'(1'b1));
        check("mid rst out_valid", 64'(out_valid), 64'(1'b0));
        check("mid rst busy", 64'(busy), 64'(1'b0));
        check("mid rst diff", 64'(diff), 64'(8'h00));
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h05, 8'h03, 1'b0, 1'b0, "post_rst", gd, gbo, gov);
        check("post_rst diff", 64'(gd), 64'(8'h02));
        check("post_rst bout", 64'(gbo), 64'(1'b0));

        // Random operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, ed, ebo, eov);
            run_op(ra, rb, rbin, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), gd, gbo, gov);
            check($sformatf("rnd%0d diff a=%0h b=%0h bin=%0b", i, ra, rb, rbin), 64'(gd), 64'(ed));
            check($sformatf("rnd%0d bout", i), 64'(gbo), 64'(ebo));
            check($sformatf("rnd%0d ovf", i), 64'(gov), 64'(eov));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
